// File: rtl/store_checker.sv
// store_checker: in-order checker for the processor store stream against a
// programmable table of expected {address, data} stores, with a RUN watchdog.
module store_checker #(
  parameter int unsigned NUM_EXP     = 8,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memwrite,
  input  logic [AW-1:0]                  dataadr,
  input  logic [DW-1:0]                  writedata,
  input  logic                           exp_wr,
  input  logic [AW-1:0]                  exp_adr,
  input  logic [DW-1:0]                  exp_dat,
  input  logic                           start,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     fail_code,
  output logic                           ovf,
  output logic [$clog2(NUM_EXP+1)-1:0]   exp_count,
  output logic [$clog2(NUM_EXP+1)-1:0]   match_count,
  output logic [31:0]                    cycle_count,
  output logic [AW-1:0]                  bad_adr,
  output logic [DW-1:0]                  bad_dat
);

  localparam int unsigned CW = $clog2(NUM_EXP + 1);
  localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int unsigned EW = AW + DW;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_EMPTY    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   exp_count_q, exp_count_d;
  logic [CW-1:0]   match_count_q, match_count_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [AW-1:0]   bad_adr_q, bad_adr_d;
  logic [DW-1:0]   bad_dat_q, bad_dat_d;
  logic [1:0]      fail_code_q, fail_code_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [EW-1:0]   table_q [NUM_EXP];
  logic            tbl_we_c;
  logic [CW-1:0]   mc_inc_c;
  logic [EW-1:0]   cur_exp_c;

  assign mc_inc_c  = CW'(match_count_q + CW'(1));
  assign cur_exp_c = table_q[match_count_q[IW-1:0]];

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    exp_count_d   = exp_count_q;
    match_count_d = match_count_q;
    cycle_count_d = cycle_count_q;
    bad_adr_d     = bad_adr_q;
    bad_dat_d     = bad_dat_q;
    fail_code_d   = fail_code_q;
    ovf_d         = ovf_q;
    done_d        = done_q;
    pass_d        = pass_q;
    tbl_we_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (exp_wr) begin
          if (exp_count_q == CW'(NUM_EXP)) begin
            ovf_d = 1'b1;
          end else begin
            tbl_we_c    = 1'b1;
            exp_count_d = CW'(exp_count_q + CW'(1));
          end
        end
        // Start uses the count after any same-cycle table write
        if (start) begin
          if (exp_count_d != '0) begin
            state_d = S_RUN;
          end else begin
            state_d     = S_FAIL;
            fail_code_d = FC_EMPTY;
            done_d      = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
        if (memwrite) begin
          if ({dataadr, writedata} == cur_exp_c) begin
            match_count_d = mc_inc_c;
            if (mc_inc_c == exp_count_q) begin
              state_d = S_PASS;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end else begin
            state_d     = S_FAIL;
            fail_code_d = FC_MISMATCH;
            done_d      = 1'b1;
            bad_adr_d   = dataadr;
            bad_dat_d   = writedata;
          end
        end
        // Watchdog only fires when no store decision was taken this edge
        if (state_d == S_RUN && cycle_count_q == 32'(TIMEOUT_CYC - 1)) begin
          state_d     = S_FAIL;
          fail_code_d = FC_TIMEOUT;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      exp_count_q   <= '0;
      match_count_q <= '0;
      cycle_count_q <= '0;
      bad_adr_q     <= '0;
      bad_dat_q     <= '0;
      fail_code_q   <= FC_NONE;
      ovf_q         <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_count_q   <= exp_count_d;
      match_count_q <= match_count_d;
      cycle_count_q <= cycle_count_d;
      bad_adr_q     <= bad_adr_d;
      bad_dat_q     <= bad_dat_d;
      fail_code_q   <= fail_code_d;
      ovf_q         <= ovf_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  // Expected-store table; contents survive reset, exp_count validates them
  always_ff @(posedge clk) begin
    if (!reset && tbl_we_c) begin
      table_q[exp_count_q[IW-1:0]] <= {exp_adr, exp_dat};
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign ovf         = ovf_q;
  assign exp_count   = exp_count_q;
  assign match_count = match_count_q;
  assign cycle_count = cycle_count_q;
  assign bad_adr     = bad_adr_q;
  assign bad_dat     = bad_dat_q;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: directed scoreboard bench for store_checker
// (NUM_EXP=4, TIMEOUT_CYC=16).
module tb_store_checker;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        exp_wr;
  logic [31:0] exp_adr;
  logic [31:0] exp_dat;
  logic        start;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic        ovf;
  logic [2:0]  exp_count;
  logic [2:0]  match_count;
  logic [31:0] cycle_count;
  logic [31:0] bad_adr;
  logic [31:0] bad_dat;

  store_checker #(
    .NUM_EXP    (4),
    .TIMEOUT_CYC(16),
    .AW         (32),
    .DW         (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .exp_wr     (exp_wr),
    .exp_adr    (exp_adr),
    .exp_dat    (exp_dat),
    .start      (start),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .ovf        (ovf),
    .exp_count  (exp_count),
    .match_count(match_count),
    .cycle_count(cycle_count),
    .bad_adr    (bad_adr),
    .bad_dat    (bad_dat)
  );

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic        ovf;
    logic [2:0]  ec;
    logic [2:0]  mc;
    logic [31:0] cc;
    logic [31:0] ba;
    logic [31:0] bd;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string f, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, o, x);
    end
  endtask

  task automatic check(input exp_t x, input string tag);
    cmp(tag, "done",        32'(done),        32'(x.done));
    cmp(tag, "pass",        32'(pass),        32'(x.pass));
    cmp(tag, "fail_code",   32'(fail_code),   32'(x.fc));
    cmp(tag, "ovf",         32'(ovf),         32'(x.ovf));
    cmp(tag, "exp_count",   32'(exp_count),   32'(x.ec));
    cmp(tag, "match_count", 32'(match_count), 32'(x.mc));
    cmp(tag, "cycle_count", cycle_count,      x.cc);
    cmp(tag, "bad_adr",     bad_adr,          x.ba);
    cmp(tag, "bad_dat",     bad_dat,          x.bd);
  endtask

  task automatic clear_inputs();
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    exp_wr = 1'b0; exp_adr = '0; exp_dat = '0; start = 1'b0;
  endtask

  // Push expectation with the stimulus, pop and compare after the edge
  task automatic do_cycle(input string tag);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    x = sb.pop_front();
    check(x, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    e = '0;
    do_cycle("reset");
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_wr = 1'b1; exp_adr = a; exp_dat = d;
    if (e.ec < 3'd4) e.ec = e.ec + 3'd1;
    else e.ovf = 1'b1;
    do_cycle("load");
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      e.cc = e.cc + 32'd1;
      do_cycle("run_idle");
    end
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
  endtask

  function automatic logic [31:0] ent_a(input int i);
    return 32'h100 + 32'(i * 4);
  endfunction

  function automatic logic [31:0] ent_d(input int i);
    return 32'hA0 + 32'(i);
  endfunction

  initial begin
    clear_inputs();
    e = '0;
    @(negedge clk);

    // Single matching store, three idle cycles after start
    do_reset();
    load(32'd84, 32'd4);
    start = 1'b1; do_cycle("start1");
    idle_run(3);
    drive_store(32'd84, 32'd4);
    e.cc = 32'd4; e.mc = 3'd1; e.done = 1'b1; e.pass = 1'b1;
    do_cycle("pass1");
    drive_store(32'd84, 32'd5); start = 1'b1;
    do_cycle("pass1_hold");

    // Mismatch captures bad store, later stores ignored
    do_reset();
    load(32'd84, 32'd4);
    start = 1'b1; do_cycle("start2");
    drive_store(32'd84, 32'd5);
    e.cc = 32'd1; e.done = 1'b1; e.fc = 2'd1; e.ba = 32'd84; e.bd = 32'd5;
    do_cycle("mismatch");
    drive_store(32'd84, 32'd4);
    do_cycle("mismatch_hold");
    exp_wr = 1'b1; exp_adr = 32'd9; exp_dat = 32'd9; start = 1'b1;
    do_cycle("mismatch_hold2");

    // Watchdog fires after exactly 16 RUN cycles
    do_reset();
    load(32'd0, 32'd7);
    start = 1'b1; do_cycle("start3");
    idle_run(15);
    e.cc = 32'd16; e.done = 1'b1; e.fc = 2'd2;
    do_cycle("timeout");
    drive_store(32'd0, 32'd7);
    do_cycle("timeout_hold");

    // Matching store on the 16th edge wins over timeout
    do_reset();
    load(32'd0, 32'd7);
    start = 1'b1; do_cycle("start4");
    idle_run(15);
    drive_store(32'd0, 32'd7);
    e.cc = 32'd16; e.mc = 3'd1; e.done = 1'b1; e.pass = 1'b1;
    do_cycle("match_beats_timeout");

    // Table overflow then in-order stores with gaps
    do_reset();
    for (int i = 0; i < 5; i++) load(ent_a(i), ent_d(i));
    start = 1'b1; do_cycle("start5");
    for (int i = 0; i < 4; i++) begin
      drive_store(ent_a(i), ent_d(i));
      e.cc = e.cc + 32'd1; e.mc = e.mc + 3'd1;
      if (i == 3) begin e.done = 1'b1; e.pass = 1'b1; end
      do_cycle("seq_store");
      if (i < 3) idle_run(1);
    end

    // Out-of-order store fails with entry 2 captured
    do_reset();
    for (int i = 0; i < 4; i++) load(ent_a(i), ent_d(i));
    start = 1'b1; do_cycle("start6");
    drive_store(ent_a(0), ent_d(0));
    e.cc = 32'd1; e.mc = 3'd1;
    do_cycle("ooo_first");
    drive_store(ent_a(2), ent_d(2));
    e.cc = 32'd2; e.done = 1'b1; e.fc = 2'd1; e.ba = ent_a(2); e.bd = ent_d(2);
    do_cycle("ooo_fail");

    // Start on empty table
    do_reset();
    start = 1'b1;
    e.done = 1'b1; e.fc = 2'd3;
    do_cycle("empty_start");

    // Write and start together on empty table enters RUN
    do_reset();
    exp_wr = 1'b1; exp_adr = 32'd84; exp_dat = 32'd4; start = 1'b1;
    e.ec = 3'd1;
    do_cycle("wr_and_start");
    drive_store(32'd84, 32'd4);
    e.cc = 32'd1; e.mc = 3'd1; e.done = 1'b1; e.pass = 1'b1;
    do_cycle("wr_and_start_pass");

    // Reset mid-RUN, then stores are ignored in IDLE
    do_reset();
    for (int i = 0; i < 3; i++) load(ent_a(i), ent_d(i));
    start = 1'b1; do_cycle("start7");
    drive_store(ent_a(0), ent_d(0));
    e.cc = 32'd1; e.mc = 3'd1;
    do_cycle("pre_reset_match");
    drive_store(ent_a(1), ent_d(1));
    do_reset();
    drive_store(ent_a(1), ent_d(1));
    do_cycle("idle_store_ignored");
    drive_store(32'd84, 32'd5);
    do_cycle("idle_store_ignored2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
